spir_master: RTL and testbench

//  Initiator end of the SPI register protocol served by the on-FPGA SPI register slave.
//  It turns single register requests into SPI frames, acting as the MCU does.
//  It also returns read data and a completion pulse for every transaction.

---
 rtl/spir_pkg.sv | 38 +++
 rtl/spir_clkgen.sv | 59 +++++
 rtl/spir_master.sv | 197 +++++++++++++++++++
 tb/tb_spir_master.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/spir_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spir_pkg
// Description : Shared definitions for the SPI register protocol: frame field
//               widths, FSM state encodings and the header packing function.
// Revision    : 1.0 - initial release
// ============================================================================
package spir_pkg;

  localparam int SPIR_HDR_W   = 16;
  localparam int SPIR_DATA_W  = 32;
  localparam int SPIR_WR_BIT  = 15;
  localparam int SPIR_ADDR_W  = 12;
  localparam int SPIR_FRAME_W = SPIR_HDR_W + SPIR_DATA_W;

  // Frame sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LEAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_TRAIL = 3'd3,
    ST_GAP   = 3'd4
  } spir_state_e;

  // Header layout: {wr, 3'b000, addr[11:0]}
  function automatic logic [SPIR_HDR_W-1:0] spir_pack_hdr(
    input logic                   wr,
    input logic [SPIR_ADDR_W-1:0] addr
  );
    logic [SPIR_HDR_W-1:0] hdr;
    hdr                    = '0;
    hdr[SPIR_WR_BIT]       = wr;
    hdr[SPIR_ADDR_W-1:0]   = addr;
    return hdr;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spir_clkgen.sv
`default_nettype none
// ============================================================================
// Module      : spir_clkgen
// Description : spi_clk divider. Counts CLK_DIV system cycles per half-period
//               and issues one-cycle tick/rise/fall strobes plus the registered
//               spi_clk level. Held in reset (count 0, clock low) when idle.
// Revision    : 1.0 - initial release
// ============================================================================
module spir_clkgen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic nreset,
  input  logic run_i,
  input  logic toggle_i,
  output logic tick_o,
  output logic rise_o,
  output logic fall_o,
  output logic sclk_o
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       sclk_q, sclk_d;

  assign tick_o = run_i && (cnt_q == DIV_LAST);
  assign rise_o = tick_o && toggle_i && !sclk_q;
  assign fall_o = tick_o && toggle_i && sclk_q;
  assign sclk_o = sclk_q;

  // Divider reloads at CLK_DIV-1 so it never wraps; spi_clk toggles on ticks
  always_comb begin
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!run_i) begin
      cnt_d  = 8'd0;
      sclk_d = 1'b0;
    end else begin
      cnt_d = tick_o ? 8'd0 : cnt_q + 8'd1;
      if (tick_o && toggle_i) begin
        sclk_d = !sclk_q;
      end
    end
  end

  // Divider state register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q  <= 8'd0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spir_master.sv
`default_nettype none
// ============================================================================
// Module      : spir_master
// Description : SPI register-protocol initiator. Converts single register
//               requests into 48-bit write or (48+TURN_BITS)-bit read frames,
//               SPI mode 0, MSB first, and returns a one-cycle completion
//               pulse with read data.
// Revision    : 1.0 - initial release
// ============================================================================
module spir_master
  import spir_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int TURN_BITS  = 8,
  parameter int GAP_CYCLES = 8,
  parameter int ADDR_W     = 12
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              spi_clk,
  output logic              spi_ncs,
  output logic              spi_do,
  input  logic              spi_di
);

  localparam logic [6:0] BITS_WR    = 7'(SPIR_FRAME_W);
  localparam logic [6:0] BITS_RD    = 7'(SPIR_FRAME_W + TURN_BITS);
  localparam logic [6:0] DATA_START = 7'(SPIR_HDR_W + TURN_BITS);
  localparam int         GAP_W      = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

  spir_state_e state_q, state_d;

  logic [SPIR_FRAME_W-1:0] tx_q, tx_d;
  logic [SPIR_DATA_W-1:0]  rx_q, rx_d;
  logic [6:0]              bit_q, bit_d;
  logic [GAP_W-1:0]        gap_q, gap_d;
  logic                    wr_q, wr_d;
  logic                    ready_q, ready_d;
  logic                    ncs_q, ncs_d;
  logic                    do_q, do_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [31:0]             rsp_rdata_q, rsp_rdata_d;
  logic                    di_meta_q, di_sync_q;

  logic                    tick, rise, fall, sclk;
  logic                    accept, last_bit, gap_done;
  logic [6:0]              bits_total;
  logic [SPIR_HDR_W-1:0]   hdr;

  assign hdr        = spir_pack_hdr(req_wr, req_addr);
  assign accept     = (state_q == ST_IDLE) && req_valid && ready_q;
  assign bits_total = wr_q ? BITS_WR : BITS_RD;
  assign last_bit   = (bit_q == bits_total - 7'd1);
  assign gap_done   = (gap_q == GAP_LAST);

  spir_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk      (clk),
    .nreset   (nreset),
    .run_i    ((state_q == ST_LEAD) || (state_q == ST_SHIFT) || (state_q == ST_TRAIL)),
    .toggle_i (state_q == ST_SHIFT),
    .tick_o   (tick),
    .rise_o   (rise),
    .fall_o   (fall),
    .sclk_o   (sclk)
  );

  // State register
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: one frame per accepted request, then a mandatory ncs-high gap
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept)           state_d = ST_LEAD;
      ST_LEAD:  if (tick)             state_d = ST_SHIFT;
      ST_SHIFT: if (fall && last_bit) state_d = ST_TRAIL;
      ST_TRAIL: if (tick)             state_d = ST_GAP;
      ST_GAP:   if (gap_done)         state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  // Output/datapath next values: shift out on falls, sample MISO on rises
  always_comb begin
    ready_d     = (state_d == ST_IDLE);
    ncs_d       = ncs_q;
    do_d        = do_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    bit_d       = bit_q;
    gap_d       = gap_q;
    wr_d        = wr_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          tx_d  = {hdr, (req_wr ? req_wdata : 32'h0)};
          wr_d  = req_wr;
          ncs_d = 1'b0;
          do_d  = hdr[SPIR_HDR_W-1];
          bit_d = 7'd0;
          rx_d  = '0;
        end
      end
      ST_SHIFT: begin
        if (rise && !wr_q && (bit_q >= DATA_START)) begin
          rx_d = {rx_q[SPIR_DATA_W-2:0], di_sync_q};
        end
        if (fall) begin
          // Bits beyond the 48-bit payload (read turnaround/data) shift out as 0
          tx_d  = {tx_q[SPIR_FRAME_W-2:0], 1'b0};
          do_d  = last_bit ? 1'b0 : tx_q[SPIR_FRAME_W-2];
          bit_d = last_bit ? bit_q : bit_q + 7'd1;
        end
      end
      ST_TRAIL: begin
        if (tick) begin
          ncs_d       = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = wr_q ? 32'h0 : rx_q;
          gap_d       = '0;
        end
      end
      ST_GAP: begin
        if (!gap_done) begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tx_q        <= '0;
      rx_q        <= '0;
      bit_q       <= 7'd0;
      gap_q       <= '0;
      wr_q        <= 1'b0;
      ready_q     <= 1'b0;
      ncs_q       <= 1'b1;
      do_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0;
    end else begin
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      bit_q       <= bit_d;
      gap_q       <= gap_d;
      wr_q        <= wr_d;
      ready_q     <= ready_d;
      ncs_q       <= ncs_d;
      do_q        <= do_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Two-flop synchroniser for the asynchronous MISO line
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      di_meta_q <= 1'b0;
      di_sync_q <= 1'b0;
    end else begin
      di_meta_q <= spi_di;
      di_sync_q <= di_meta_q;
    end
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign spi_clk   = sclk;
  assign spi_ncs   = ncs_q;
  assign spi_do    = do_q;

endmodule
`default_nettype wire

// File: tb/tb_spir_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_spir_master
// Description : Directed self-checking bench for spir_master. A behavioural
//               slave decodes MOSI, stores writes and serves reads on MISO.
//               A second instance covers CLK_DIV=255 / TURN_BITS=0.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spir_master;

  localparam int TURN = 8;
  localparam int GAP  = 8;

  logic        clk = 1'b0;
  logic        nreset = 1'b0, nreset2 = 1'b0;
  logic        req_valid = 1'b0, req_wr = 1'b0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, rsp_valid, spi_clk, spi_ncs, spi_do;
  logic [31:0] rsp_rdata;
  logic        spi_di = 1'b0;

  logic        req_valid2 = 1'b0, req_wr2 = 1'b0;
  logic [11:0] req_addr2 = '0;
  logic [31:0] req_wdata2 = '0;
  logic        req_ready2, rsp_valid2, spi_clk2, spi_ncs2, spi_do2;
  logic [31:0] rsp_rdata2;
  wire         spi_di2 = ~spi_ncs2;

  int n_pass = 0, n_total = 0;
  int cyc = 0, acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  spir_master #(.CLK_DIV(4), .TURN_BITS(TURN), .GAP_CYCLES(GAP), .ADDR_W(12)) dut (
    .clk(clk), .nreset(nreset), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .spi_clk(spi_clk),
    .spi_ncs(spi_ncs), .spi_do(spi_do), .spi_di(spi_di));

  spir_master #(.CLK_DIV(255), .TURN_BITS(0), .GAP_CYCLES(1), .ADDR_W(12)) dut2 (
    .clk(clk), .nreset(nreset2), .req_valid(req_valid2), .req_ready(req_ready2),
    .req_wr(req_wr2), .req_addr(req_addr2), .req_wdata(req_wdata2),
    .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2), .spi_clk(spi_clk2),
    .spi_ncs(spi_ncs2), .spi_do(spi_do2), .spi_di(spi_di2));

  // ---------------- behavioural slave for dut ----------------
  logic [31:0] mem [4096];
  logic [63:0] mosi_sr = '0;
  logic [15:0] hdr_seen = '0;
  logic        prev_do = 1'b0;
  int          rise_cnt = 0, fall_cnt = 0, do_glitch = 0, rise_cnt2 = 0;

  always @(negedge clk) prev_do = spi_do;

  always @(negedge spi_ncs) begin
    mosi_sr  = '0;
    rise_cnt = 0;
    fall_cnt = 0;
  end

  always @(posedge spi_clk) begin
    if (spi_do !== prev_do) do_glitch++;
    mosi_sr = {mosi_sr[62:0], spi_do};
    rise_cnt++;
  end

  always @(negedge spi_clk) begin
    if (!spi_ncs) begin
      fall_cnt++;
      if (fall_cnt == 16) hdr_seen = mosi_sr[15:0];
      if (!hdr_seen[15] && fall_cnt >= 16 + TURN && fall_cnt < 48 + TURN)
        spi_di = mem[hdr_seen[11:0]][31 - (fall_cnt - 16 - TURN)];
      else
        spi_di = 1'b0;
    end
  end

  always @(posedge spi_ncs) begin
    spi_di = 1'b0;
    if (rise_cnt == 48 && hdr_seen[15]) mem[hdr_seen[11:0]] = mosi_sr[31:0];
  end

  always @(negedge spi_ncs2) rise_cnt2 = 0;
  always @(posedge spi_clk2) rise_cnt2++;

  // ---------------- helpers (stimulus only) ----------------
  task automatic send(input logic wr, input logic [11:0] addr, input logic [31:0] data,
                      input logic hold);
    int n;
    @(negedge clk);
    req_wr = wr; req_addr = addr; req_wdata = data; req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 2000) begin @(negedge clk); n++; end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    int n;
    n = 0;
    while (!rsp_valid && n < 2000) begin @(posedge clk); #1; n++; end
    lat = rsp_valid ? (cyc - acc_cyc + 1) : -1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (5) begin
      @(posedge clk); #1;
      n_total++;
      if ({spi_ncs, spi_clk, rsp_valid, req_ready, spi_do, spi_ncs2} !== 6'b100001)
        $display("FAIL reset_outputs: got ncs/clk/rsp/rdy/do/ncs2=%b required 100001",
                 {spi_ncs, spi_clk, rsp_valid, req_ready, spi_do, spi_ncs2});
      else n_pass++;
    end
    n_total++;
    if (rsp_rdata !== 32'h0) $display("FAIL reset_rdata: got %h required 00000000", rsp_rdata);
    else n_pass++;
    @(negedge clk); nreset = 1'b1; nreset2 = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if ({req_ready, req_ready2} !== 2'b11)
      $display("FAIL ready_after_reset: got %b required 11", {req_ready, req_ready2});
    else n_pass++;
  endtask

  task automatic test_read();
    int lat;
    send(1'b0, 12'h040, 32'h0, 1'b0);
    wait_rsp(lat);
    n_total++;
    if (lat !== 457) $display("FAIL read_latency: got %0d required 457", lat); else n_pass++;
    n_total++;
    if (rsp_rdata !== 32'h12345678) $display("FAIL read_data: got %h required 12345678", rsp_rdata);
    else n_pass++;
    n_total++;
    if (rise_cnt !== 56) $display("FAIL read_edges: got %0d required 56", rise_cnt); else n_pass++;
    n_total++;
    if (mosi_sr[55:32] !== 24'h0040_00)
      $display("FAIL read_header: got %h required 004000", mosi_sr[55:32]);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h12345678)
      $display("FAIL rsp_pulse_hold: got valid=%b data=%h required 0 12345678", rsp_valid, rsp_rdata);
    else n_pass++;
  endtask

  task automatic test_write();
    int lat;
    send(1'b1, 12'h2A0, 32'hDEADBEEF, 1'b0);
    wait_rsp(lat);
    n_total++;
    if (lat !== 393) $display("FAIL write_latency: got %0d required 393", lat); else n_pass++;
    n_total++;
    if (rsp_rdata !== 32'h0) $display("FAIL write_rdata: got %h required 00000000", rsp_rdata);
    else n_pass++;
    n_total++;
    if (rise_cnt !== 48 || mosi_sr[47:0] !== 48'h82A0_DEADBEEF)
      $display("FAIL write_mosi: got %0d edges %h required 48 edges 82a0deadbeef", rise_cnt, mosi_sr[47:0]);
    else n_pass++;
    n_total++;
    if (spi_ncs !== 1'b1) $display("FAIL write_ncs_end: got %b required 1", spi_ncs); else n_pass++;
    send(1'b0, 12'h2A0, 32'h0, 1'b0);
    wait_rsp(lat);
    n_total++;
    if (rsp_rdata !== 32'hDEADBEEF) $display("FAIL write_readback: got %h required deadbeef", rsp_rdata);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat, k;
    send(1'b1, 12'h111, 32'hA5A50F0F, 1'b1);
    req_wr = 1'b0; req_addr = 12'h111; req_wdata = 32'hFFFF_FFFF;
    wait_rsp(lat);
    n_total++;
    if (lat !== 393) $display("FAIL b2b_write_latency: got %0d required 393", lat); else n_pass++;
    k = 0;
    while (spi_ncs && k < 100) begin @(posedge clk); #1; k++; end
    req_valid = 1'b0;
    acc_cyc = cyc;
    n_total++;
    if (k !== GAP + 1) $display("FAIL b2b_gap: got %0d ncs-high cycles required %0d", k, GAP + 1);
    else n_pass++;
    wait_rsp(lat);
    n_total++;
    if (lat !== 457) $display("FAIL b2b_read_latency: got %0d required 457", lat); else n_pass++;
    n_total++;
    if (rsp_rdata !== 32'hA5A50F0F) $display("FAIL b2b_read_data: got %h required a5a50f0f", rsp_rdata);
    else n_pass++;
    n_total++;
    if (do_glitch !== 0) $display("FAIL mosi_stable: got %0d changes at rising edges required 0", do_glitch);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int n, lat, seen;
    send(1'b1, 12'h155, 32'h0BADF00D, 1'b0);
    n = 0;
    while (rise_cnt < 20 && n < 2000) begin @(posedge clk); #1; n++; end
    #2 nreset = 1'b0;
    #1;
    n_total++;
    if ({spi_ncs, spi_clk, req_ready, spi_do} !== 4'b1000)
      $display("FAIL abort_async: got ncs/clk/rdy/do=%b required 1000", {spi_ncs, spi_clk, req_ready, spi_do});
    else n_pass++;
    seen = 0;
    repeat (4) begin @(posedge clk); #1; if (rsp_valid) seen++; end
    @(negedge clk); nreset = 1'b1;
    repeat (3) begin @(posedge clk); #1; if (rsp_valid) seen++; end
    n_total++;
    if (seen !== 0) $display("FAIL abort_no_rsp: got %0d pulses required 0", seen); else n_pass++;
    n_total++;
    if (mem[12'h155] !== 32'h0) $display("FAIL abort_dropped: got %h required 00000000", mem[12'h155]);
    else n_pass++;
    send(1'b1, 12'h155, 32'h0BADF00D, 1'b0);
    wait_rsp(lat);
    n_total++;
    if (lat !== 393) $display("FAIL abort_next_latency: got %0d required 393", lat); else n_pass++;
    n_total++;
    if (rise_cnt !== 48 || mosi_sr[47:0] !== 48'h8155_0BADF00D)
      $display("FAIL abort_next_frame: got %0d edges %h required 48 edges 81550badf00d", rise_cnt, mosi_sr[47:0]);
    else n_pass++;
  endtask

  task automatic test_slow_read();
    int n, half, a2;
    @(negedge clk);
    req_wr2 = 1'b0; req_addr2 = 12'h3FF; req_valid2 = 1'b1;
    n = 0;
    while (!req_ready2 && n < 100) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    a2 = cyc;
    req_valid2 = 1'b0;
    n = 0;
    while (!spi_clk2 && n < 2000) begin @(posedge clk); #1; n++; end
    n_total++;
    if (cyc - a2 !== 510) $display("FAIL slow_first_rise: got %0d required 510", cyc - a2); else n_pass++;
    half = 0;
    while (spi_clk2 && half < 1000) begin @(posedge clk); #1; half++; end
    n_total++;
    if (half !== 255) $display("FAIL slow_half_period: got %0d required 255", half); else n_pass++;
    n = 0;
    while (!rsp_valid2 && n < 30000) begin @(posedge clk); #1; n++; end
    n_total++;
    if (!rsp_valid2 || (cyc - a2 + 1) !== 24991)
      $display("FAIL slow_latency: got %0d required 24991", rsp_valid2 ? cyc - a2 + 1 : -1);
    else n_pass++;
    n_total++;
    if (rsp_rdata2 !== 32'hFFFFFFFF) $display("FAIL slow_data: got %h required ffffffff", rsp_rdata2);
    else n_pass++;
    n_total++;
    if (rise_cnt2 !== 48) $display("FAIL slow_edges: got %0d required 48", rise_cnt2); else n_pass++;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[12'h040] = 32'h12345678;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_reset_midframe();
    test_slow_read();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
